// File: rtl/mem_responder.sv
// Memory-side responder: single-word writes and critical-word-first line-fill reads
// from an on-chip synchronous word array, with a fixed ack latency and read gap.
module mem_responder #(
  parameter int MEM_AW    = 10,
  parameter int ACK_LAT   = 2,
  parameter int RD_GAP    = 2,
  parameter int BURST_LEN = 2
) (
  input  logic        CPU_CLK,
  input  logic        RST,
  input  logic        mem_do_act,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dataintomem,
  input  logic        ext_hold,
  output logic        mem_grant,
  output logic        mem_ack,
  output logic [31:0] mem_datafrommem,
  output logic        mem_rd_vld,
  output logic        mem_busy,
  output logic        mem_oob
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WAIT    = 3'd1;
  localparam logic [2:0] S_ACK     = 3'd2;
  localparam logic [2:0] S_GAP     = 3'd3;
  localparam logic [2:0] S_BURST   = 3'd4;
  localparam logic [2:0] S_REFRACT = 3'd5;

  localparam logic [2:0] WAIT_END = 3'((ACK_LAT > 1) ? ACK_LAT - 2 : 0);
  localparam logic [2:0] GAP_END  = 3'((RD_GAP > 1) ? RD_GAP - 2 : 0);
  localparam logic [2:0] BEAT_END = 3'(BURST_LEN - 1);
  localparam logic [MEM_AW-1:0] BLK_MASK = MEM_AW'(BURST_LEN - 1);

  logic [31:0]       mem_array [2**MEM_AW];
  logic [2:0]        state;
  logic [2:0]        cnt;
  logic [MEM_AW-1:0] addr_q;
  logic              we_q;
  logic              accept;
  logic              rd_en;
  logic [MEM_AW-1:0] beat_sel;
  logic [MEM_AW-1:0] rd_idx;

  assign accept     = (state == S_IDLE) && mem_do_act && mem_grant;
  assign mem_ack    = (state == S_ACK);
  assign mem_rd_vld = (state == S_BURST);
  assign mem_busy   = (state != S_IDLE);

  // Read address is issued the cycle before each beat so registered data lines up with mem_rd_vld.
  always_comb begin
    rd_en    = 1'b0;
    beat_sel = '0;
    case (state)
      S_ACK:   rd_en = !we_q && (RD_GAP == 1);
      S_GAP:   rd_en = (cnt == GAP_END);
      S_BURST: begin
        rd_en    = (cnt != BEAT_END);
        beat_sel = MEM_AW'(cnt) + MEM_AW'(1);
      end
      default: rd_en = 1'b0;
    endcase
    rd_idx = (addr_q & ~BLK_MASK) | ((addr_q + beat_sel) & BLK_MASK);
  end

  always_ff @(posedge CPU_CLK) begin
    if (RST && accept && mem_we)
      mem_array[mem_addr[MEM_AW-1:0]] <= mem_dataintomem;
  end

  always_ff @(posedge CPU_CLK) begin
    if (!RST) begin
      state           <= S_IDLE;
      cnt             <= '0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      mem_grant       <= 1'b0;
      mem_oob         <= 1'b0;
      mem_datafrommem <= '0;
    end else begin
      mem_grant <= !ext_hold;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= mem_addr[MEM_AW-1:0];
            we_q    <= mem_we;
            cnt     <= '0;
            mem_oob <= mem_oob | (|(mem_addr >> MEM_AW));
            state   <= (ACK_LAT == 1) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == WAIT_END) begin
            cnt   <= '0;
            state <= S_ACK;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_ACK: begin
          cnt <= '0;
          if (we_q)             state <= S_REFRACT;
          else if (RD_GAP == 1) state <= S_BURST;
          else                  state <= S_GAP;
        end
        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= S_BURST;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_BURST: begin
          if (cnt == BEAT_END) state <= S_REFRACT;
          else                 cnt   <= cnt + 3'd1;
        end
        S_REFRACT: begin
          if (!mem_do_act) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (rd_en)
        mem_datafrommem <= mem_array[rd_idx];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed and randomized transactions checked
// against a word-array model and cycle schedule derived from the latency parameters.
module tb_mem_responder;

  localparam int AW = 10;
  localparam int AL = 2;
  localparam int RG = 2;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        do_act;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hold;
  logic        grant;
  logic        ack;
  logic [31:0] dout;
  logic        vld;
  logic        busy;
  logic        oob;

  logic [31:0] ref_mem [2**AW];
  logic [31:0] last_dout;
  int tests = 0;
  int fails = 0;

  mem_responder #(
    .MEM_AW   (AW),
    .ACK_LAT  (AL),
    .RD_GAP   (RG),
    .BURST_LEN(BL)
  ) dut (
    .CPU_CLK        (clk),
    .RST            (rst),
    .mem_do_act     (do_act),
    .mem_we         (we),
    .mem_addr       (addr),
    .mem_dataintomem(wdata),
    .ext_hold       (hold),
    .mem_grant      (grant),
    .mem_ack        (ack),
    .mem_datafrommem(dout),
    .mem_rd_vld     (vld),
    .mem_busy       (busy),
    .mem_oob        (oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observation i is taken just after the i-th edge following acceptance.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold_c);
    int ack_i, last_i, drop_i, idle_i, k;
    logic [AW-1:0] widx;
    do_act = 1'b1;
    we     = w;
    addr   = a;
    wdata  = d;
    tick();
    if (w) ref_mem[AW'(a % (2**AW))] = d;
    ack_i  = AL - 1;
    last_i = w ? ack_i : ack_i + RG + BL - 1;
    drop_i = ack_i + hold_c;
    idle_i = (last_i + 2 > drop_i + 1) ? last_i + 2 : drop_i + 1;
    for (int i = 0; i <= idle_i; i++) begin
      k = i - (ack_i + RG);
      chk("ack", 32'(ack), 32'(i == ack_i));
      chk("rd_vld", 32'(vld), 32'(!w && k >= 0 && k < BL));
      chk("busy", 32'(busy), 32'(i < idle_i));
      if (!w && k >= 0 && k < BL) begin
        widx = AW'(((a % (2**AW)) / BL) * BL + ((a % BL) + k) % BL);
        last_dout = ref_mem[widx];
      end
      chk("data", dout, last_dout);
      if (i == drop_i) do_act = 1'b0;
      if (i < idle_i) tick();
    end
  endtask

  initial begin
    rst = 1'b0; do_act = 1'b0; we = 1'b0; addr = '0; wdata = '0; hold = 1'b0;
    last_dout = '0;
    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_oob", 32'(oob), 32'd0);
    chk("rst_data", dout, 32'd0);
    rst = 1'b1;
    tick();
    chk("grant_up", 32'(grant), 32'd1);

    // Preload the low block range so every read hits written words.
    for (int a = 0; a < 16; a++) txn(1'b1, 32'(a), $urandom, 0);

    txn(1'b1, 32'h005, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h005, '0, 0);
    txn(1'b1, 32'h004, 32'h11, 0);
    txn(1'b1, 32'h005, 32'h22, 0);
    txn(1'b0, 32'h005, '0, 0);
    chk("crit_last", dout, 32'h11);

    for (int n = 0; n < 12; n++)
      txn(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, $urandom_range(0, 2));

    // Request held long after ack: only one ack and one burst.
    txn(1'b0, 32'($urandom_range(0, 15)), '0, 10);
    txn(1'b0, 32'($urandom_range(0, 15)), '0, 0);

    hold = 1'b1;
    tick();
    chk("grant_drop", 32'(grant), 32'd0);
    do_act = 1'b1; we = 1'b0; addr = 32'h006;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_ack", 32'(ack), 32'd0);
      chk("hold_grant", 32'(grant), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("grant_back", 32'(grant), 32'd1);
    chk("grant_back_busy", 32'(busy), 32'd0);
    txn(1'b0, 32'h006, '0, 0);

    chk("oob_clear", 32'(oob), 32'd0);
    txn(1'b0, 32'h00000407, '0, 0);
    chk("oob_set", 32'(oob), 32'd1);
    txn(1'b1, 32'h003, $urandom, 0);
    chk("oob_sticky", 32'(oob), 32'd1);

    do_act = 1'b1; we = 1'b0; addr = 32'($urandom_range(0, 15));
    tick();
    repeat (AL - 1 + RG) tick();
    chk("beat0_vld", 32'(vld), 32'd1);
    rst = 1'b0; do_act = 1'b0;
    tick();
    chk("mid_rst_vld", 32'(vld), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_data", dout, 32'd0);
    chk("mid_rst_oob", 32'(oob), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    rst = 1'b1;
    last_dout = '0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'd1);
    txn(1'b0, 32'($urandom_range(0, 15)), '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
